// File: rtl/serial_to_parallel.sv
// Frame-based serial-to-parallel assembler, MSB first; word and one-cycle load pulse registered at the last-bit edge.
// No backpressure: bits are taken whenever bit_valid is high in a frame; a start during a frame restarts it with frame_err.
module serial_to_parallel #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            bit_valid,
    input  logic            ser_in,
    output logic [SIZE-1:0] data,
    output logic            load,
    output logic            busy,
    output logic            frame_err
);

    localparam int CNT_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   sh_q, sh_d;
    logic [SIZE-1:0]   data_q, data_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic [SIZE-1:0]   shifted;

    // Oldest bit falls off the top; the incoming bit enters at the LSB.
    assign shifted = SIZE'({sh_q, ser_in});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        data_d      = data_q;
        load_d      = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            SHIFT: begin
                // A restart wins over a bit offered in the same cycle.
                if (start) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    sh_d        = '0;
                end else if (bit_valid) begin
                    if (cnt_q == LAST) begin
                        data_d  = shifted;
                        load_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (SIZE=4) with a model of the downstream enable-load register.
module tb_serial_to_parallel;

    localparam int SIZE = 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            bit_valid;
    logic            ser_in;
    logic [SIZE-1:0] data;
    logic            load;
    logic            busy;
    logic            frame_err;
    logic [SIZE-1:0] q;

    int n_checks;
    int n_fail;

    serial_to_parallel #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .ser_in    (ser_in),
        .data      (data),
        .load      (load),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Downstream register: captures data only when load is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= '0;
        else if (load) q <= data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            st;
        logic            bv;
        logic            si;
        logic [SIZE-1:0] exp_data;
        logic            exp_load;
        logic            exp_busy;
        logic            exp_err;
        logic [SIZE-1:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic bv, input logic si,
                       input logic [SIZE-1:0] d, input logic l, input logic b,
                       input logic e, input logic [SIZE-1:0] dq);
        vec_t v;
        v.st = st; v.bv = bv; v.si = si;
        v.exp_data = d; v.exp_load = l; v.exp_busy = b; v.exp_err = e; v.exp_q = dq;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [SIZE-1:0] d, input logic l,
                              input logic b, input logic e);
        check({tag, "_data"}, 32'(data), 32'(d));
        check({tag, "_load"}, 32'(load), 32'(l));
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_err"},  32'(frame_err), 32'(e));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step(input logic st, input logic bv, input logic si);
        start = st; bit_valid = bv; ser_in = si;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_hold(input string tag);
        for (int c = 0; c < 2; c++) begin
            start     = 1'($urandom_range(0, 1));
            bit_valid = 1'($urandom_range(0, 1));
            ser_in    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_outs($sformatf("%s_hold%0d", tag, c), '0, 1'b0, 1'b0, 1'b0);
        end
        start = 1'b0; bit_valid = 1'b0; ser_in = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Basic frame 1011
        add(1,0,0, 4'h0,0,1,0, 4'h0);
        add(0,1,1, 4'h0,0,1,0, 4'h0);
        add(0,1,0, 4'h0,0,1,0, 4'h0);
        add(0,1,1, 4'h0,0,1,0, 4'h0);
        add(0,1,1, 4'hB,1,0,0, 4'h0);
        add(0,0,0, 4'hB,0,0,0, 4'hB);
        // IDLE bits ignored, then gapped frame 0110
        add(0,1,1, 4'hB,0,0,0, 4'hB);
        add(1,1,1, 4'hB,0,1,0, 4'hB);
        add(0,1,0, 4'hB,0,1,0, 4'hB);
        add(0,0,1, 4'hB,0,1,0, 4'hB);
        add(0,1,1, 4'hB,0,1,0, 4'hB);
        add(0,0,0, 4'hB,0,1,0, 4'hB);
        add(0,0,1, 4'hB,0,1,0, 4'hB);
        add(0,1,1, 4'hB,0,1,0, 4'hB);
        add(0,0,0, 4'hB,0,1,0, 4'hB);
        add(0,0,1, 4'hB,0,1,0, 4'hB);
        add(0,0,0, 4'hB,0,1,0, 4'hB);
        add(0,1,0, 4'h6,1,0,0, 4'hB);
        add(0,1,1, 4'h6,0,0,0, 4'h6);
        // Restart mid-frame: bits 1,0 then start (offered bit discarded), then 1111
        add(1,0,0, 4'h6,0,1,0, 4'h6);
        add(0,1,1, 4'h6,0,1,0, 4'h6);
        add(0,1,0, 4'h6,0,1,0, 4'h6);
        add(1,1,0, 4'h6,0,1,1, 4'h6);
        add(0,1,1, 4'h6,0,1,0, 4'h6);
        add(0,1,1, 4'h6,0,1,0, 4'h6);
        add(0,1,1, 4'h6,0,1,0, 4'h6);
        add(0,1,1, 4'hF,1,0,0, 4'h6);
        add(0,0,0, 4'hF,0,0,0, 4'hF);
        // Back-to-back 1001 then 1000 with start in the load cycle
        add(1,0,0, 4'hF,0,1,0, 4'hF);
        add(0,1,1, 4'hF,0,1,0, 4'hF);
        add(0,1,0, 4'hF,0,1,0, 4'hF);
        add(0,1,0, 4'hF,0,1,0, 4'hF);
        add(0,1,1, 4'h9,1,0,0, 4'hF);
        add(1,0,0, 4'h9,0,1,0, 4'h9);
        add(0,1,1, 4'h9,0,1,0, 4'h9);
        add(0,1,0, 4'h9,0,1,0, 4'h9);
        add(0,1,0, 4'h9,0,1,0, 4'h9);
        add(0,1,0, 4'h8,1,0,0, 4'h9);
        add(0,0,0, 4'h8,0,0,0, 4'h8);

        // Reset state
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; ser_in = 1'b0;
        #1;
        check_outs("rst_init", '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_outs("rst_init_hold", '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].bv, vecs[i].si);
            check_outs($sformatf("row%0d", i), vecs[i].exp_data, vecs[i].exp_load,
                       vecs[i].exp_busy, vecs[i].exp_err);
            check($sformatf("row%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
        end

        // Asynchronous reset landing mid-cycle while load is high
        step(1,0,0);
        step(0,1,1);
        step(0,1,1);
        step(0,1,0);
        step(0,1,1);
        check_outs("pre_rst", 4'hD, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", '0, 1'b0, 1'b0, 1'b0);
        check("async_rst_q", 32'(q), 32'h0);
        @(posedge clk);
        #1;
        reset_hold("rstA");
        step(0,0,0);
        check_outs("rstA_rel", '0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame aborts silently, then a clean frame 0101
        step(1,0,0);
        step(0,1,1);
        step(0,1,1);
        step(0,1,1);
        check_outs("rstB_mid", '0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        reset_hold("rstB");
        step(0,0,0);
        check_outs("rstB_rel", '0, 1'b0, 1'b0, 1'b0);
        step(1,0,0);
        check_outs("rstB_start", '0, 1'b0, 1'b1, 1'b0);
        step(0,1,0);
        step(0,1,1);
        step(0,1,0);
        check_outs("rstB_b3", '0, 1'b0, 1'b1, 1'b0);
        step(0,1,1);
        check_outs("rstB_load", 4'h5, 1'b1, 1'b0, 1'b0);
        step(0,0,0);
        check_outs("rstB_after", 4'h5, 1'b0, 1'b0, 1'b0);
        check("rstB_q", 32'(q), 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
